input_process_spi: RTL and testbench

- Receive-side counterpart of the output SPI path.
- Deserializes a bit stream (one bit per CLK, MSB first) delimited by a last-bit strobe into 16-bit words.
- Buffers the words in a small first-word-fall-through FIFO and hands them to system logic through a VALID/RD handshake.
- Drives a STOP back-pressure line to the remote transmitter when the FIFO nears full, and flags framing errors and overflow.

---
 rtl/input_process_spi.sv | 158 +++++++++++++++
 tb/tb_input_process_spi.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/input_process_spi.sv
// input_process_spi: receive-side SPI deserializer.
// Shifts in one bit per CLK (MSB first), frames 16-bit words on RX_LOAD,
// rejects short frames, and buffers accepted words in a first-word-fall-through
// FIFO read through a VALID/RD handshake. TX_STOP throttles the remote sender.
module input_process_spi #(
    parameter int DEPTH       = 8,
    parameter int AW          = 3,
    parameter int STOP_MARGIN = 2
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          RX_DATA,
    input  logic          RX_LOAD,
    output logic          TX_STOP,
    output logic [15:0]   DATA,
    output logic          VALID,
    input  logic          RD,
    output logic [AW:0]   USEDW,
    output logic          OVERFLOW,
    output logic [7:0]    ERR_CNT
);

    // Occupancy thresholds expressed at the width of USEDW.
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
    localparam logic [AW:0] STOP_LVL = (AW+1)'(DEPTH - STOP_MARGIN);
    // A frame needs at least 16 bits; the counter reads 15 on the 16th bit.
    localparam logic [4:0]  MIN_GAP  = 5'd15;
    localparam logic [4:0]  GAP_MAX  = 5'd31;
    localparam logic [7:0]  ERR_MAX  = 8'd255;

    // Registered state.
    logic [14:0]   sr_q,        sr_d;
    logic [4:0]    gap_q,       gap_d;
    logic [AW-1:0] wr_ptr_q,    wr_ptr_d;
    logic [AW-1:0] rd_ptr_q,    rd_ptr_d;
    logic [AW:0]   usedw_q,     usedw_d;
    logic          valid_q,     valid_d;
    logic [15:0]   data_q,      data_d;
    logic          overflow_q,  overflow_d;
    logic [7:0]    err_cnt_q,   err_cnt_d;

    // Word storage.
    logic [15:0]   mem_q [DEPTH];

    // Per-cycle decode.
    logic [15:0]   word;
    logic          frame_ok;
    logic          accept;
    logic          short_frame;
    logic          full;
    logic          pop;
    logic          push;
    logic [AW-1:0] rd_next;
    logic [AW:0]   remain;

    // Next-state logic for the deserializer, frame checker and FIFO bookkeeping.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        word        = {sr_q, RX_DATA};
        frame_ok    = (gap_q >= MIN_GAP);
        accept      = RX_LOAD && frame_ok;
        short_frame = RX_LOAD && !frame_ok;
        full        = (usedw_q == FULL_LVL);
        pop         = RD && valid_q;
        // A full FIFO still takes the word when a pop frees a slot on the same edge.
        push        = accept && (!full || pop);

        sr_d        = {sr_q[13:0], RX_DATA};
        gap_d       = gap_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        usedw_d     = usedw_q + (AW+1)'(push) - (AW+1)'(pop);
        overflow_d  = overflow_q;
        err_cnt_d   = err_cnt_q;
        rd_next     = rd_ptr_q;
        remain      = usedw_q - (AW+1)'(pop);
        data_d      = data_q;

        // Gap counter: distance from the previous RX_LOAD (or reset).
        if (RX_LOAD) begin
            gap_d = '0;
        end else if (gap_q != GAP_MAX) begin
            gap_d = gap_q + 5'd1;
        end

        if (short_frame && err_cnt_q != ERR_MAX) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end

        if (accept && !push) begin
            overflow_d = 1'b1;
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end

        if (pop) begin
            rd_next  = rd_ptr_q + AW'(1);
            rd_ptr_d = rd_next;
        end

        valid_d = (usedw_d != '0);

        // Head register: the incoming word falls through when nothing older
        // survives this edge; otherwise the next stored entry is presented.
        // With nothing to present DATA keeps its last value.
        if (usedw_d != '0) begin
            if (remain == '0) begin
                data_d = word;
            end else begin
                data_d = mem_q[rd_next];
            end
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (RST) begin
            sr_q       <= '0;
            gap_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            usedw_q    <= '0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            overflow_q <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            sr_q       <= sr_d;
            gap_q      <= gap_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            usedw_q    <= usedw_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            overflow_q <= overflow_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    // FIFO storage write port.
    always_ff @(posedge CLK) begin
        // NOTE: the array is deliberately not reset; entries are read only after being written.
        if (push) begin
            mem_q[wr_ptr_q] <= word;
        end
    end

    assign DATA     = data_q;
    assign VALID    = valid_q;
    assign USEDW    = usedw_q;
    assign OVERFLOW = overflow_q;
    assign ERR_CNT  = err_cnt_q;
    assign TX_STOP  = (usedw_q >= STOP_LVL);

endmodule

// File: tb/tb_input_process_spi.sv
// Testbench for input_process_spi: directed table of operations with hand
// expectations, plus randomized traffic compared every cycle against a
// queue-based reference model.
module tb_input_process_spi;

    localparam int DEPTH       = 8;
    localparam int AW          = 3;
    localparam int STOP_MARGIN = 2;

    logic          CLK;
    logic          RST;
    logic          RX_DATA;
    logic          RX_LOAD;
    logic          RD;
    logic          TX_STOP;
    logic [15:0]   DATA;
    logic          VALID;
    logic [AW:0]   USEDW;
    logic          OVERFLOW;
    logic [7:0]    ERR_CNT;

    input_process_spi #(
        .DEPTH       (DEPTH),
        .AW          (AW),
        .STOP_MARGIN (STOP_MARGIN)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .RX_DATA  (RX_DATA),
        .RX_LOAD  (RX_LOAD),
        .TX_STOP  (TX_STOP),
        .DATA     (DATA),
        .VALID    (VALID),
        .RD       (RD),
        .USEDW    (USEDW),
        .OVERFLOW (OVERFLOW),
        .ERR_CNT  (ERR_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: FIFO as a queue, bit count since last frame boundary.
    logic [15:0] m_q[$];
    logic [14:0] m_hist;
    int          m_nbits;
    logic        m_ovf;
    int          m_err;
    logic [15:0] m_data;

    typedef enum logic [2:0] {OP_RST, OP_FRAME, OP_FRAME_RD, OP_POP, OP_BITS} op_e;

    typedef struct {
        op_e         op;
        logic [15:0] word;
        int          nbits;
        logic        exp_valid;
        logic [15:0] exp_data;
        int          exp_usedw;
        logic        exp_stop;
        logic        exp_ovf;
        int          exp_err;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: actual %0h required %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_step(input logic rst, input logic d, input logic load, input logic rd);
        logic [15:0] word;
        logic        do_pop;
        logic        was_full;
        if (rst) begin
            m_q.delete();
            m_hist  = '0;
            m_nbits = 0;
            m_ovf   = 1'b0;
            m_err   = 0;
            m_data  = '0;
        end else begin
            word     = {m_hist, d};
            was_full = (m_q.size() == DEPTH);
            do_pop   = rd && (m_q.size() > 0);
            m_nbits++;
            if (do_pop) void'(m_q.pop_front());
            if (load) begin
                if (m_nbits >= 16) begin
                    if (was_full && !do_pop) m_ovf = 1'b1;
                    else m_q.push_back(word);
                end else if (m_err < 255) begin
                    m_err++;
                end
                m_nbits = 0;
            end
            m_hist = {m_hist[13:0], d};
            if (m_q.size() > 0) m_data = m_q[0];
        end
    endtask

    // One clock: advance the model with the current inputs, clock the DUT, compare.
    task automatic tick();
        model_step(RST, RX_DATA, RX_LOAD, RD);
        @(posedge CLK);
        #1;
        cyc++;
        check("valid",    {31'd0, VALID},    {31'd0, m_q.size() != 0});
        check("data",     {16'd0, DATA},     {16'd0, m_data});
        check("usedw",    32'(USEDW),        32'(m_q.size()));
        check("tx_stop",  {31'd0, TX_STOP},  {31'd0, m_q.size() >= DEPTH - STOP_MARGIN});
        check("overflow", {31'd0, OVERFLOW}, {31'd0, m_ovf});
        check("err_cnt",  {24'd0, ERR_CNT},  32'(m_err));
    endtask

    task automatic run_op(input op_e op, input logic [15:0] word, input int nbits);
        case (op)
            OP_RST: begin
                RST = 1'b1; RX_LOAD = 1'b0; RD = 1'b0; RX_DATA = 1'b0;
                tick();
                RST = 1'b0;
            end
            OP_POP: begin
                RD = 1'b1; RX_LOAD = 1'b0; RX_DATA = 1'b0;
                tick();
                RD = 1'b0;
            end
            default: begin
                for (int b = nbits - 1; b >= 0; b--) begin
                    RX_DATA = word[b];
                    RX_LOAD = (b == 0) && (op != OP_BITS);
                    RD      = (b == 0) && (op == OP_FRAME_RD);
                    tick();
                end
                RX_LOAD = 1'b0;
                RD      = 1'b0;
            end
        endcase
    endtask

    task automatic add(input op_e op, input logic [15:0] word, input int nbits,
                       input logic v, input logic [15:0] d, input int u,
                       input logic s, input logic o, input int e);
        vec_t t;
        t.op = op; t.word = word; t.nbits = nbits;
        t.exp_valid = v; t.exp_data = d; t.exp_usedw = u;
        t.exp_stop = s; t.exp_ovf = o; t.exp_err = e;
        tbl.push_back(t);
    endtask

    initial begin
        int gap_left;
        int rd_pct;
        int r;
        logic [15:0] pop_data [8];
        RST = 1'b1; RX_DATA = 1'b0; RX_LOAD = 1'b0; RD = 1'b0;

        // Directed sequence: op, word, nbits, then valid/data/usedw/stop/ovf/err after it.
        add(OP_RST,   16'h0000,  0, 0, 16'h0000, 0, 0, 0, 0);
        add(OP_FRAME, 16'hA5C3, 16, 1, 16'hA5C3, 1, 0, 0, 0);
        add(OP_POP,   16'h0000,  0, 0, 16'hA5C3, 0, 0, 0, 0);
        add(OP_FRAME, 16'h0001, 16, 1, 16'h0001, 1, 0, 0, 0);
        add(OP_FRAME, 16'h8000, 16, 1, 16'h0001, 2, 0, 0, 0);
        add(OP_FRAME, 16'hFFFF, 16, 1, 16'h0001, 3, 0, 0, 0);
        add(OP_POP,   16'h0000,  0, 1, 16'h8000, 2, 0, 0, 0);
        add(OP_POP,   16'h0000,  0, 1, 16'hFFFF, 1, 0, 0, 0);
        add(OP_POP,   16'h0000,  0, 0, 16'hFFFF, 0, 0, 0, 0);
        add(OP_FRAME, 16'h0155, 10, 0, 16'hFFFF, 0, 0, 0, 1);
        add(OP_FRAME, 16'h1234, 16, 1, 16'h1234, 1, 0, 0, 1);
        add(OP_POP,   16'h0000,  0, 0, 16'h1234, 0, 0, 0, 1);
        for (int i = 0; i < 8; i++)
            add(OP_FRAME, 16'hC000 + 16'(i), 16, 1, 16'hC000, i + 1, (i + 1) >= 6, 0, 1);
        add(OP_FRAME,    16'hC008, 16, 1, 16'hC000, 8, 1, 1, 1);
        add(OP_FRAME_RD, 16'hC009, 16, 1, 16'hC001, 8, 1, 1, 1);
        pop_data = '{16'hC002, 16'hC003, 16'hC004, 16'hC005,
                     16'hC006, 16'hC007, 16'hC009, 16'hC009};
        for (int i = 0; i < 8; i++)
            add(OP_POP, 16'h0000, 0, (7 - i) > 0, pop_data[i], 7 - i, (7 - i) >= 6, 1, 1);
        for (int i = 0; i < 5; i++)
            add(OP_FRAME, 16'hD000 + 16'(i), 16, 1, 16'hD000, i + 1, 0, 1, 1);
        add(OP_BITS,  16'h0055,  7, 1, 16'hD000, 5, 0, 1, 1);
        add(OP_RST,   16'h0000,  0, 0, 16'h0000, 0, 0, 0, 0);
        add(OP_FRAME, 16'h0155, 10, 0, 16'h0000, 0, 0, 0, 1);
        add(OP_FRAME, 16'hBEEF, 16, 1, 16'hBEEF, 1, 0, 0, 1);

        for (int i = 0; i < tbl.size(); i++) begin
            run_op(tbl[i].op, tbl[i].word, tbl[i].nbits);
            check($sformatf("tbl%0d_valid", i), {31'd0, VALID},    {31'd0, tbl[i].exp_valid});
            check($sformatf("tbl%0d_data", i),  {16'd0, DATA},     {16'd0, tbl[i].exp_data});
            check($sformatf("tbl%0d_usedw", i), 32'(USEDW),        32'(tbl[i].exp_usedw));
            check($sformatf("tbl%0d_stop", i),  {31'd0, TX_STOP},  {31'd0, tbl[i].exp_stop});
            check($sformatf("tbl%0d_ovf", i),   {31'd0, OVERFLOW}, {31'd0, tbl[i].exp_ovf});
            check($sformatf("tbl%0d_err", i),   {24'd0, ERR_CNT},  32'(tbl[i].exp_err));
        end

        // Error counter saturation: RX_LOAD every cycle is always a short frame.
        run_op(OP_RST, 16'h0000, 0);
        for (int i = 0; i < 260; i++) begin
            RX_DATA = 1'($urandom);
            RX_LOAD = 1'b1;
            tick();
        end
        RX_LOAD = 1'b0;
        check("err_saturated", {24'd0, ERR_CNT}, 32'd255);
        check("err_no_write",  32'(USEDW),       32'd0);

        // Long idle gap (gap counter saturates) followed by a normal frame.
        for (int i = 0; i < 40; i++) begin
            RX_DATA = 1'($urandom);
            tick();
        end
        run_op(OP_FRAME, 16'h5A5A, 16);
        check("long_gap_data",  {16'd0, DATA}, 32'h5A5A);
        check("long_gap_usedw", 32'(USEDW),    32'd1);

        // Randomized traffic against the reference model.
        run_op(OP_RST, 16'h0000, 0);
        gap_left = 15;
        for (int c = 0; c < 5000; c++) begin
            rd_pct  = ((c / 400) % 2 == 1) ? 10 : 60;
            RST     = ($urandom_range(0, 799) == 0);
            RX_DATA = 1'($urandom);
            if (gap_left == 0) begin
                RX_LOAD = 1'b1;
                r = $urandom_range(0, 9);
                if (r == 0)      gap_left = $urandom_range(0, 14);
                else if (r == 1) gap_left = $urandom_range(16, 45);
                else             gap_left = 15;
            end else begin
                RX_LOAD = 1'b0;
                gap_left--;
            end
            RD = ($urandom_range(0, 99) < rd_pct);
            tick();
        end
        RST = 1'b0; RX_LOAD = 1'b0; RD = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
